// File: rtl/data_memory_ctrl.sv
// Parametrised data memory for the FIR datapath: init sweep with coefficient
// preload, write protection, error flags, busy/ready handshake. Macro DMEM_WR_FWD_EN selects write-first reads.
module data_memory_ctrl #(
  parameter int                         DATA_W    = 8,
  parameter int                         ADDR_W    = 8,
  parameter int                         DEPTH     = 256,
  parameter int                         COEF_BASE = 100,
  parameter int                         COEF_NUM  = 4,
  parameter logic [COEF_NUM*DATA_W-1:0] COEF_INIT = {8'h00, 8'h81, 8'h01, 8'h80},
  parameter bit                         PROTECT   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic              ready,
  output logic              busy,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              wr_err,
  output logic              rd_err
);

  typedef enum logic {ST_INIT, ST_IDLE} state_e;

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   COEF_LO  = (ADDR_W+1)'(COEF_BASE);
  localparam logic [ADDR_W:0]   COEF_HI  = (ADDR_W+1)'(COEF_BASE + COEF_NUM);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   init_ptr_q, init_ptr_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                wr_err_q, wr_err_d;
  logic                rd_err_q, rd_err_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                addr_in_range;
  logic                addr_protected;
  logic                wr_ok;
  logic                wr_acc;
  logic [DATA_W-1:0]   init_word;
  logic [DATA_W-1:0]   rd_word;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  assign addr_in_range  = {1'b0, addr} < DEPTH_C;
  assign addr_protected = PROTECT && ({1'b0, addr} >= COEF_LO) && ({1'b0, addr} < COEF_HI);
  assign wr_ok          = addr_in_range && !addr_protected;
  // init_req in IDLE takes priority: concurrent requests are dropped silently.
  assign wr_acc         = (state_q == ST_IDLE) && !init_req && wr_en && wr_ok;

  always_comb begin
    init_word = '0;
    for (int k = 0; k < COEF_NUM; k++) begin
      if ({1'b0, init_ptr_q} == COEF_LO + (ADDR_W+1)'(k)) begin
        init_word = COEF_INIT[k*DATA_W +: DATA_W];
      end
    end
  end

`ifdef DMEM_WR_FWD_EN
  assign rd_word = wr_acc ? wr_data : mem_q[addr];
`else
  assign rd_word = mem_q[addr];
`endif

  assign mem_we    = (state_q == ST_INIT) || wr_acc;
  assign mem_waddr = (state_q == ST_INIT) ? init_ptr_q : addr;
  assign mem_wdata = (state_q == ST_INIT) ? init_word  : wr_data;

  // NOTE: the array has no reset; the init sweep gives it defined contents instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_err_d   = 1'b0;
    wr_err_d   = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (init_ptr_q == LAST_PTR) begin
          state_d    = ST_IDLE;
          init_ptr_d = '0;
        end else begin
          init_ptr_d = init_ptr_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (init_req) begin
          state_d    = ST_INIT;
          init_ptr_d = '0;
        end else begin
          if (rd_en) begin
            rd_valid_d = 1'b1;
            rd_err_d   = !addr_in_range;
            rd_data_d  = addr_in_range ? rd_word : '0;
          end
          wr_err_d = wr_en && !wr_ok;
        end
      end
      default: begin
        state_d    = ST_INIT;
        init_ptr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_err_q   <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wr_err_q   <= wr_err_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign busy     = (state_q == ST_INIT);
  assign ready    = ~busy;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign wr_err   = wr_err_q;
  assign rd_err   = rd_err_q;

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised successor to the 8-bit/256-word data memory used by the FIR datapath.
- Word width, depth and coefficient-preload region are all configurable.
- After reset, or on request, a sequential init engine sweeps the array: zeros everywhere, coefficient constants in the preload region.
- Provides a registered read port, write protection on the coefficient region, error flags, and a busy/ready handshake for the FIR controller.

Parameters:
- DATA_W, 8, word width in bits.
- ADDR_W, 8, address width.
- DEPTH, 256, number of words; must be <= 2**ADDR_W.
- COEF_BASE, 100, first address of the coefficient region.
- COEF_NUM, 4, number of words in the coefficient region; COEF_BASE+COEF_NUM must be <= DEPTH.
- COEF_INIT, {8'h00,8'h81,8'h01,8'h80}, packed COEF_NUM*DATA_W preload values; word k is slice [k*DATA_W +: DATA_W].
- PROTECT, 1, when 1 the coefficient region is read-only to the write port.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- init_req  in  1  single-cycle pulse; restarts the init sweep when the block is idle.
- addr  in  ADDR_W  read/write address.
- wr_data  in  DATA_W  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- ready  out  1  equals ~busy; requests are accepted only when ready=1.
- busy  out  1  init sweep in progress.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  one-cycle pulse qualifying rd_data.
- wr_err  out  1  one-cycle pulse: a write was rejected.
- rd_err  out  1  one-cycle pulse, coincident with rd_valid: read address was out of range.

Behaviour:
- Reset (async, rst=1):
  - state=INIT, init_ptr=0, busy=1.
  - rd_valid=0, rd_data=0, wr_err=0, rd_err=0.
  - Array contents are not cleared combinationally.
- State machine, two states: INIT and IDLE.
- INIT:
  - On each clk after rst deasserts, writes mem[init_ptr] = COEF_INIT word (init_ptr−COEF_BASE) if init_ptr is in [COEF_BASE, COEF_BASE+COEF_NUM), else 0.
  - init_ptr increments by 1 per cycle.
  - At init_ptr==DEPTH-1 the state moves to IDLE; busy falls on the following edge.
  - Full sweep is exactly DEPTH cycles.
- IDLE:
  - init_req=1 → INIT, with init_ptr=0 and busy=1 from the next edge.
  - If init_req coincides with rd_en or wr_en, init_req wins and the requests are dropped with no error flag.
- Requests while busy=1 are ignored: no write, no rd_valid, no error.
- rst asserted mid-sweep restarts the sweep from 0.
- Read:
  - rd_en and ready sampled at edge N → rd_data=mem[addr], rd_valid=1 after edge N+1 (latency 1).
  - rd_data holds its last value while rd_valid=0.
- Write:
  - wr_en and ready → mem[addr]=wr_data at the edge.
  - Rejected, with wr_err pulsed for 1 cycle, if addr>=DEPTH, or if PROTECT=1 and addr is in the coefficient region.
- Out-of-range read (addr>=DEPTH): rd_data=0, rd_valid=1, rd_err=1.
- Simultaneous rd_en and wr_en on the same address: read returns the old contents (read-before-write), unless the optional feature below is compiled in.
- Rejected writes never alter contents, including for forwarding.

Optional Feature:
- Macro: DMEM_WR_FWD_EN.
- When defined: a same-cycle accepted write to the read address forwards wr_data to rd_data (write-first).
- When not defined: read-before-write as described above.
- A rejected write is never forwarded in either case.

Test Plan:
- Reset, then wait DEPTH cycles: busy=1 for exactly 256 cycles, then ready=1. Reads give addr100=0x80, 101=0x01, 102=0x81, 103=0x00, addr3=0x00, each with rd_valid one cycle after rd_en.
- Write 0x07 to addr1, then read addr1 → rd_data=0x07, rd_valid=1 one cycle later. Write 0x55 to addr101 → wr_err pulse, and readback of addr101 is still 0x01.
- Set DEPTH=200 and read addr 210 → rd_data=0, rd_err=1, rd_valid=1. Write to addr 210 → wr_err=1.
- Same-cycle write 0xAA and read at addr5, which holds 0x00 → without the macro rd_data=0x00; with DMEM_WR_FWD_EN rd_data=0xAA.
- Write 0x33 to addr7, pulse init_req, then assert rd_en during busy → no rd_valid. After the 256-cycle sweep, addr7 reads 0x00.
- Assert rst at sweep cycle 50, release, then count cycles → busy stays high for a full 256 cycles after release, and coefficients read back correctly.
